// File: rtl/cache_refill_pkg.sv
// Shared types and helpers for the cache miss/refill sequencer.
// Supports up to 32 ways (bin2onehot result width).
package cache_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VICTIM = 2'd1,
    ST_FETCH  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam int MAX_WAYS = 32;

  function automatic int way_w(input int n_ways);
    return (n_ways > 1) ? $clog2(n_ways) : 1;
  endfunction

  // Word-offset fields keep at least one bit so 1-word lines still have a port.
  function automatic int off_w(input int line_off_w);
    return (line_off_w > 0) ? line_off_w : 1;
  endfunction

  function automatic logic [MAX_WAYS-1:0] bin2onehot(input logic [4:0] idx);
    return MAX_WAYS'(1) << idx;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of lookup, replacement-policy, back-end memory and array-write
// signals around cache_refill_ctrl; slave is the controller, master the rest.
interface cache_refill_ctrl_if
  import cache_refill_pkg::*;
#(
  parameter int N_WAYS     = 4,
  parameter int LINE_OFF_W = 2,
  parameter int LINE_W     = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
);
  localparam int WAY_W = way_w(N_WAYS);
  localparam int OFF_W = off_w(LINE_OFF_W);

  // Handshakes: a lookup is taken in any cycle with req_valid & req_ready;
  // a memory word moves when mem_valid & mem_ready, mem_valid/mem_addr stay
  // stable until then, and mem_ready without mem_valid carries no meaning.
  logic                req_valid;
  logic [ADDR_W-1:0]   req_addr;
  logic                hit;
  logic [N_WAYS-1:0]   hit_way;
  logic                req_ready;

  logic                rp_write_en;
  logic [N_WAYS-1:0]   rp_way_hit;
  logic [LINE_W-1:0]   rp_line_addr;
  logic [WAY_W-1:0]    rp_way_select;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  logic                data_we;
  logic [N_WAYS-1:0]   data_way;
  logic [OFF_W-1:0]    data_off;
  logic [DATA_W-1:0]   data_wdata;
  logic                tag_we;
  logic                busy;

  modport slave (
    input  req_valid, req_addr, hit, hit_way, rp_way_select, mem_rdata, mem_ready,
    output req_ready, rp_write_en, rp_way_hit, rp_line_addr, mem_valid, mem_addr,
           data_we, data_way, data_off, data_wdata, tag_we, busy
  );

  modport master (
    output req_valid, req_addr, hit, hit_way, rp_way_select, mem_rdata, mem_ready,
    input  req_ready, rp_write_en, rp_way_hit, rp_line_addr, mem_valid, mem_addr,
           data_we, data_way, data_off, data_wdata, tag_we, busy
  );

endinterface

// File: rtl/refill_word_cnt.sv
// Word-within-line counter for refills: clear, enable, wrap on last word.
// With LINE_OFF_W = 0 the count is pinned at 0, so last_o is always 1.
module refill_word_cnt
  import cache_refill_pkg::*;
#(
  parameter int LINE_OFF_W = 2,
  parameter int OFF_W      = off_w(LINE_OFF_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [OFF_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [OFF_W-1:0] LAST = OFF_W'((2 ** LINE_OFF_W) - 1);

  logic [OFF_W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + OFF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer: serialises policy updates for hits and refills.
// Optional hit/miss counters are built when CACHE_REFILL_CTRL_PERF_EN is defined.
module cache_refill_ctrl
  import cache_refill_pkg::*;
#(
  parameter int N_WAYS     = 4,
  parameter int LINE_OFF_W = 2,
  parameter int LINE_W     = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32
) (
  input  logic   clk,
  input  logic   reset,
`ifdef CACHE_REFILL_CTRL_PERF_EN
  input  logic        cnt_clr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  output state_e state_o,
  cache_refill_ctrl_if.slave bus
);

  localparam int WAY_W = way_w(N_WAYS);
  localparam int OFF_W = off_w(LINE_OFF_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((2 ** LINE_OFF_W) - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic               hit_pend_q, hit_pend_d;
  logic [N_WAYS-1:0]  hit_way_q, hit_way_d;
  logic [LINE_W-1:0]  hit_line_q, hit_line_d;

  logic [OFF_W-1:0]   word_cnt;
  logic               word_last;
  logic               cnt_clear;
  logic               cnt_en;
  logic               lookup_hit;
  logic [LINE_W-1:0]  req_line;
  logic [LINE_W-1:0]  lat_line;
  logic [N_WAYS-1:0]  victim_oh;

  assign req_line   = bus.req_addr[LINE_OFF_W +: LINE_W];
  assign lat_line   = addr_q[LINE_OFF_W +: LINE_W];
  assign lookup_hit = bus.hit & (|bus.hit_way);
  assign victim_oh  = N_WAYS'(bin2onehot(5'(victim_q)));
  assign state_o    = state_q;

  refill_word_cnt #(
    .LINE_OFF_W (LINE_OFF_W)
  ) u_word_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clear),
    .en_i   (cnt_en),
    .cnt_o  (word_cnt),
    .last_o (word_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    victim_d    = victim_q;
    hit_pend_d  = 1'b0;
    hit_way_d   = hit_way_q;
    hit_line_d  = hit_line_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    bus.req_ready    = 1'b0;
    bus.rp_write_en  = 1'b0;
    bus.rp_way_hit   = '0;
    bus.rp_line_addr = lat_line;
    bus.mem_valid    = 1'b0;
    bus.mem_addr     = (addr_q & ~OFF_MASK) | ADDR_W'(word_cnt);
    bus.data_we      = 1'b0;
    bus.data_way     = victim_oh;
    bus.data_off     = word_cnt;
    bus.data_wdata   = bus.mem_rdata;
    bus.tag_we       = 1'b0;
    bus.busy         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready    = 1'b1;
        bus.rp_line_addr = req_line;
        if (bus.req_valid) begin
          if (lookup_hit) begin
            hit_pend_d = 1'b1;
            hit_way_d  = bus.hit_way;
            hit_line_d = req_line;
          end else begin
            addr_d  = bus.req_addr;
            state_d = ST_VICTIM;
          end
        end
      end
      ST_VICTIM: begin
        bus.busy  = 1'b1;
        victim_d  = bus.rp_way_select;
        cnt_clear = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_FETCH: begin
        bus.busy      = 1'b1;
        bus.mem_valid = 1'b1;
        if (bus.mem_ready) begin
          bus.data_we = 1'b1;
          cnt_en      = 1'b1;
          if (word_last) begin
            bus.tag_we = 1'b1;
            state_d    = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        bus.busy        = 1'b1;
        bus.rp_write_en = 1'b1;
        bus.rp_way_hit  = victim_oh;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A hit registered last cycle owns the policy port this cycle.
    if (hit_pend_q) begin
      bus.rp_write_en  = 1'b1;
      bus.rp_way_hit   = hit_way_q;
      bus.rp_line_addr = hit_line_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      victim_q   <= '0;
      hit_pend_q <= 1'b0;
      hit_way_q  <= '0;
      hit_line_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      victim_q   <= victim_d;
      hit_pend_q <= hit_pend_d;
      hit_way_q  <= hit_way_d;
      hit_line_q <= hit_line_d;
    end
  end

`ifdef CACHE_REFILL_CTRL_PERF_EN
  logic        acc_hit, acc_miss;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign acc_hit  = (state_q == ST_IDLE) & bus.req_valid & lookup_hit;
  assign acc_miss = (state_q == ST_IDLE) & bus.req_valid & ~lookup_hit;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Counters saturate; a clear wins over a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (acc_hit && (hit_cnt_q != '1)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end
      if (acc_miss && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a default build (4-word lines) and a
// 1-word-line build side by side, checked with immediate assertions.
module tb_cache_refill_ctrl;
  import cache_refill_pkg::*;

  logic   clk;
  logic   reset;
  state_e st0, st1;
  int     n_cmp;
  int     n_err;
  logic [11:0] exp_q[$];

  cache_refill_ctrl_if #(.N_WAYS(4), .LINE_OFF_W(2), .LINE_W(4), .ADDR_W(12), .DATA_W(32)) bus0 ();
  cache_refill_ctrl_if #(.N_WAYS(4), .LINE_OFF_W(0), .LINE_W(4), .ADDR_W(12), .DATA_W(32)) bus1 ();

`ifdef CACHE_REFILL_CTRL_PERF_EN
  logic        cnt_clr;
  logic [31:0] hc0, mc0, hc1, mc1;
`endif

  cache_refill_ctrl #(.N_WAYS(4), .LINE_OFF_W(2), .LINE_W(4), .ADDR_W(12), .DATA_W(32)) dut0 (
    .clk      (clk),
    .reset    (reset),
`ifdef CACHE_REFILL_CTRL_PERF_EN
    .cnt_clr  (cnt_clr),
    .hit_cnt  (hc0),
    .miss_cnt (mc0),
`endif
    .state_o  (st0),
    .bus      (bus0)
  );

  cache_refill_ctrl #(.N_WAYS(4), .LINE_OFF_W(0), .LINE_W(4), .ADDR_W(12), .DATA_W(32)) dut1 (
    .clk      (clk),
    .reset    (reset),
`ifdef CACHE_REFILL_CTRL_PERF_EN
    .cnt_clr  (cnt_clr),
    .hit_cnt  (hc1),
    .miss_cnt (mc1),
`endif
    .state_o  (st1),
    .bus      (bus1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_req0(input logic v, input logic [11:0] a, input logic h, input logic [3:0] w);
    bus0.req_valid = v;
    bus0.req_addr  = a;
    bus0.hit       = h;
    bus0.hit_way   = w;
  endtask

  // Entered just after an edge with dut0 in FETCH and mem_ready low; the word
  // is returned on the lat-th cycle and its address comes off exp_q.
  task automatic fetch_word0(input int lat, input logic [31:0] d, input logic [1:0] off,
                             input logic [3:0] way, input logic last);
    for (int c = 0; c < lat - 1; c++) begin
      #1;
      chk("wait_mem_valid", bus0.mem_valid, 1'b1);
      chk("wait_data_we", bus0.data_we, 1'b0);
      tick();
    end
    bus0.mem_ready = 1'b1;
    bus0.mem_rdata = d;
    #1;
    chk("mem_valid", bus0.mem_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1'b1, 1'b0);
    end else begin
      chk("mem_addr", bus0.mem_addr, exp_q.pop_front());
    end
    chk("data_we", bus0.data_we, 1'b1);
    chk("data_way", bus0.data_way, way);
    chk("data_off", bus0.data_off, off);
    chk("data_wdata", bus0.data_wdata, d);
    chk("tag_we", bus0.tag_we, last);
    tick();
    bus0.mem_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    bus0.rp_way_select = 2'd0;
    bus0.mem_rdata = '0;
    bus0.mem_ready = 1'b0;
    bus1.req_valid = 1'b0;
    bus1.req_addr  = '0;
    bus1.hit       = 1'b0;
    bus1.hit_way   = '0;
    bus1.rp_way_select = 2'd0;
    bus1.mem_rdata = '0;
    bus1.mem_ready = 1'b0;
`ifdef CACHE_REFILL_CTRL_PERF_EN
    cnt_clr = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", st0, ST_IDLE);
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_mem_valid", bus0.mem_valid, 1'b0);
    chk("rst_rp_we", bus0.rp_write_en, 1'b0);
    chk("rst_rp_way", bus0.rp_way_hit, 4'b0000);
    chk("rst_tag_we", bus0.tag_we, 1'b0);
    chk("rst_req_ready", bus0.req_ready, 1'b1);

    // mem_ready without a request is ignored
    tick();
    bus0.mem_ready = 1'b1;
    #1;
    chk("idle_ready_data_we", bus0.data_we, 1'b0);
    chk("idle_ready_tag_we", bus0.tag_we, 1'b0);
    tick();
    bus0.mem_ready = 1'b0;
    #1;
    chk("idle_ready_state", st0, ST_IDLE);

    // Single hit at 0x034, way 2
    tick();
    drive_req0(1'b1, 12'h034, 1'b1, 4'b0100);
    #1;
    chk("hit_req_ready", bus0.req_ready, 1'b1);
    chk("hit_line_now", bus0.rp_line_addr, 4'hD);
    chk("hit_we_now", bus0.rp_write_en, 1'b0);
    tick();
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    #1;
    chk("hit_upd_we", bus0.rp_write_en, 1'b1);
    chk("hit_upd_way", bus0.rp_way_hit, 4'b0100);
    chk("hit_upd_line", bus0.rp_line_addr, 4'hD);
    chk("hit_upd_ready", bus0.req_ready, 1'b1);
    tick();
    #1;
    chk("hit_upd_once", bus0.rp_write_en, 1'b0);

    // Miss at 0x034, victim way 2, two cycles per word
    tick();
    bus0.rp_way_select = 2'd2;
    drive_req0(1'b1, 12'h034, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h034 + 12'(i));
    #1;
    chk("miss_req_ready", bus0.req_ready, 1'b1);
    tick();
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    #1;
    chk("victim_state", st0, ST_VICTIM);
    chk("victim_busy", bus0.busy, 1'b1);
    chk("victim_ready", bus0.req_ready, 1'b0);
    chk("victim_line", bus0.rp_line_addr, 4'hD);
    tick();
    fetch_word0(2, 32'hA000_0000, 2'd0, 4'b0100, 1'b0);
    fetch_word0(2, 32'hA000_0011, 2'd1, 4'b0100, 1'b0);
    fetch_word0(2, 32'hA000_0022, 2'd2, 4'b0100, 1'b0);
    fetch_word0(2, 32'hA000_0033, 2'd3, 4'b0100, 1'b1);
    #1;
    chk("upd_state", st0, ST_UPDATE);
    chk("upd_we", bus0.rp_write_en, 1'b1);
    chk("upd_way", bus0.rp_way_hit, 4'b0100);
    chk("upd_line", bus0.rp_line_addr, 4'hD);
    chk("upd_busy", bus0.busy, 1'b1);
    chk("upd_ready", bus0.req_ready, 1'b0);
    tick();
    #1;
    chk("post_ready", bus0.req_ready, 1'b1);
    chk("post_busy", bus0.busy, 1'b0);
    chk("post_we", bus0.rp_write_en, 1'b0);

    // Back-to-back hits then a miss, victim way 3, one cycle per word
    tick();
    drive_req0(1'b1, 12'h010, 1'b1, 4'b0001);
    #1;
    chk("b2b_we0", bus0.rp_write_en, 1'b0);
    tick();
    drive_req0(1'b1, 12'h0FC, 1'b1, 4'b1000);
    #1;
    chk("b2b_we1", bus0.rp_write_en, 1'b1);
    chk("b2b_way1", bus0.rp_way_hit, 4'b0001);
    chk("b2b_line1", bus0.rp_line_addr, 4'h4);
    tick();
    bus0.rp_way_select = 2'd3;
    drive_req0(1'b1, 12'h080, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h080 + 12'(i));
    #1;
    chk("b2b_we2", bus0.rp_write_en, 1'b1);
    chk("b2b_way2", bus0.rp_way_hit, 4'b1000);
    chk("b2b_line2", bus0.rp_line_addr, 4'hF);
    chk("b2b_miss_ready", bus0.req_ready, 1'b1);
    tick();
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    #1;
    chk("b2b_victim", st0, ST_VICTIM);
    chk("b2b_victim_we", bus0.rp_write_en, 1'b0);
    chk("b2b_victim_line", bus0.rp_line_addr, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      fetch_word0(1, 32'hB0B0_0000 + 32'(i), 2'(i), 4'b1000, (i == 3));
    end
    #1;
    chk("b2b_upd_way", bus0.rp_way_hit, 4'b1000);
    chk("b2b_upd_line", bus0.rp_line_addr, 4'h0);
    tick();
    #1;
    chk("b2b_idle", st0, ST_IDLE);

    // hit with hit_way = 0 is a miss; reset during the second word aborts
    tick();
    bus0.rp_way_select = 2'd1;
    drive_req0(1'b1, 12'h1A4, 1'b1, 4'b0000);
    #1;
    chk("zhit_ready", bus0.req_ready, 1'b1);
    tick();
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    #1;
    chk("zhit_victim", st0, ST_VICTIM);
    tick();
    exp_q.push_back(12'h1A4);
    fetch_word0(1, 32'hC0DE_0000, 2'd0, 4'b0010, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_word1_addr", bus0.mem_addr, 12'h1A5);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_state", st0, ST_IDLE);
    chk("abort_mem_valid", bus0.mem_valid, 1'b0);
    chk("abort_tag_we", bus0.tag_we, 1'b0);
    chk("abort_busy", bus0.busy, 1'b0);
    tick();
    drive_req0(1'b1, 12'h1A4, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) exp_q.push_back(12'h1A4 + 12'(i));
    tick();
    drive_req0(1'b0, 12'h000, 1'b0, 4'b0000);
    #1;
    chk("restart_line", bus0.rp_line_addr, 4'h9);
    tick();
    for (int i = 0; i < 4; i++) begin
      fetch_word0(1, 32'hD00D_0000 + 32'(i), 2'(i), 4'b0010, (i == 3));
    end
    #1;
    chk("restart_upd_way", bus0.rp_way_hit, 4'b0010);
    chk("restart_upd_line", bus0.rp_line_addr, 4'h9);
    tick();
    #1;
    chk("restart_idle_ready", bus0.req_ready, 1'b1);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // 1-word lines: one request, data_we and tag_we together
    tick();
    bus1.rp_way_select = 2'd1;
    bus1.req_valid = 1'b1;
    bus1.req_addr  = 12'h034;
    bus1.hit       = 1'b0;
    #1;
    chk("w1_ready", bus1.req_ready, 1'b1);
    chk("w1_line", bus1.rp_line_addr, 4'h4);
    tick();
    bus1.req_valid = 1'b0;
    #1;
    chk("w1_victim", st1, ST_VICTIM);
    tick();
    #1;
    chk("w1_fetch", st1, ST_FETCH);
    chk("w1_mem_valid", bus1.mem_valid, 1'b1);
    chk("w1_mem_addr", bus1.mem_addr, 12'h034);
    chk("w1_no_we", bus1.data_we, 1'b0);
    tick();
    bus1.mem_ready = 1'b1;
    bus1.mem_rdata = 32'h1234_5678;
    #1;
    chk("w1_hold_addr", bus1.mem_addr, 12'h034);
    chk("w1_data_we", bus1.data_we, 1'b1);
    chk("w1_tag_we", bus1.tag_we, 1'b1);
    chk("w1_data_off", bus1.data_off, 1'b0);
    chk("w1_data_way", bus1.data_way, 4'b0010);
    chk("w1_wdata", bus1.data_wdata, 32'h1234_5678);
    tick();
    bus1.mem_ready = 1'b0;
    #1;
    chk("w1_upd_state", st1, ST_UPDATE);
    chk("w1_upd_we", bus1.rp_write_en, 1'b1);
    chk("w1_upd_way", bus1.rp_way_hit, 4'b0010);
    chk("w1_upd_line", bus1.rp_line_addr, 4'h4);
    chk("w1_upd_mem_valid", bus1.mem_valid, 1'b0);
    tick();
    #1;
    chk("w1_idle_ready", bus1.req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
